itcm_arb: RTL and testbench

Two-port arbiter and sequencer for the single-port instruction TCM. It sits between instruction fetch, the data-side requester (load/store and boot-loader writes into ITCM), and the ITCM macro. It grants one access per cycle and routes the 1-cycle-latency read data back to the requester that issued it. It also cancels in-flight fetch responses on a pipeline redirect and bounds fetch starvation under back-to-back data traffic.

---
 rtl/itcm_arb.sv | 116 +++++++++++
 tb/tb_itcm_arb.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itcm_arb.sv
// itcm_arb -- access arbiter and response sequencer for the single-port
// instruction TCM.
//
// Grants at most one ITCM access per cycle to either instruction fetch or the
// data-side requester, drives the macro, and routes the one-cycle-latency read
// data back to whichever port issued the read. Data traffic normally wins a
// conflict, but after STARVE_MAX consecutive conflicting data grants the fetch
// port is forced through. A redirect (if_kill) suppresses the fetch response
// presented in the same cycle.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   if_req/if_addr      fetch read request and byte address
//   if_gnt              fetch request accepted this cycle
//   if_kill             discard the fetch response due this cycle
//   if_rvalid/if_rdata  fetch read response
//   dp_req/dp_we/dp_be  data request, write flag, write byte enables
//   dp_addr/dp_wdata    data byte address and write data
//   dp_gnt              data request accepted this cycle
//   dp_rvalid/dp_rdata  data read response
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata  ITCM macro controls (word address)
//   mem_rdata           ITCM read data, one cycle after a read enable
module itcm_arb #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    input  logic        if_kill,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dp_req,
    input  logic        dp_we,
    input  logic [3:0]  dp_be,
    input  logic [31:0] dp_addr,
    input  logic [31:0] dp_wdata,
    output logic        dp_gnt,
    output logic        dp_rvalid,
    output logic [31:0] dp_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_IF   = 2'd1;
    localparam logic [1:0] RESP_DP   = 2'd2;

    logic [3:0] starve_cnt;
    logic [1:0] resp_sel;
    logic [1:0] resp_sel_nxt;
    logic       fetch_forced;
    logic       dp_write;

    // Word-aligned ITCM: the byte-offset bits carry no information here.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{if_addr[1:0], dp_addr[1:0]};

    assign fetch_forced = (starve_cnt == 4'(STARVE_MAX));

    // Grants are held off while reset is asserted so nothing reaches the
    // macro during reset, even though reset is asynchronous to the requests.
    assign if_gnt = ~reset & if_req & (~dp_req | fetch_forced);
    assign dp_gnt = ~reset & dp_req & ~(if_req & fetch_forced);

    assign dp_write  = dp_gnt & dp_we;
    assign mem_en    = if_gnt | dp_gnt;
    assign mem_we    = dp_write;
    assign mem_be    = dp_write ? dp_be : 4'hF;
    assign mem_addr  = dp_gnt ? dp_addr[31:2] : if_addr[31:2];
    assign mem_wdata = dp_wdata;

    // Counts consecutive cycles in which fetch wanted the macro but data took
    // it. Once it reaches STARVE_MAX fetch wins, which clears it again, so it
    // never exceeds STARVE_MAX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (if_gnt || !if_req) begin
            starve_cnt <= 4'd0;
        end else if (dp_gnt) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Writes produce no response, so only read grants tag the next cycle.
    always_comb begin
        resp_sel_nxt = RESP_NONE;
        if (if_gnt) begin
            resp_sel_nxt = RESP_IF;
        end else if (dp_gnt && !dp_we) begin
            resp_sel_nxt = RESP_DP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_sel <= RESP_NONE;
        end else begin
            resp_sel <= resp_sel_nxt;
        end
    end

    // Response stage: data is shared by both ports and left unqualified;
    // consumers gate on their own rvalid.
    assign if_rvalid = (resp_sel == RESP_IF) & ~if_kill;
    assign dp_rvalid = (resp_sel == RESP_DP);
    assign if_rdata  = mem_rdata;
    assign dp_rdata  = mem_rdata;

endmodule

// File: tb/tb_itcm_arb.sv
module tb_itcm_arb;

    localparam int STARVE = 4;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_kill;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dp_req;
    logic        dp_we;
    logic [3:0]  dp_be;
    logic [31:0] dp_addr;
    logic [31:0] dp_wdata;
    logic        dp_gnt;
    logic        dp_rvalid;
    logic [31:0] dp_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    itcm_arb #(.STARVE_MAX(STARVE)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_kill(if_kill),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dp_req(dp_req), .dp_we(dp_we), .dp_be(dp_be), .dp_addr(dp_addr),
        .dp_wdata(dp_wdata), .dp_gnt(dp_gnt), .dp_rvalid(dp_rvalid), .dp_rdata(dp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int unsigned ncyc = 0;
    bit mon_en = 0;

    always @(posedge clk) ncyc <= ncyc + 1;

    typedef struct {
        int unsigned at;
        bit          is_if;
        bit          is_dp;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: word contents as the requesters should see them,
    // and the number of consecutive cycles fetch has been passed over.
    logic [31:0] ref_mem [256];
    int          losses = 0;
    bit          last_if, last_dp;

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        if (i == 8'h40) return 32'h0000_0013;
        if (i == 8'h81) return 32'h0000_0000;
        return {b, ~b, b ^ 8'h5A, b + 8'd3};
    endfunction

    // ITCM macro behaviour: synchronous write with byte enables, read data
    // registered one cycle after the enable.
    initial begin
        logic [31:0] mem [256];
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) mem[mem_addr[7:0]][8*b +: 8] = mem_wdata[8*b +: 8];
                end else begin
                    mem_rdata <= mem[mem_addr[7:0]];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One request cycle: drive, check grant/macro outputs against the model,
    // and queue the expected response.
    task automatic step(input bit ir, input logic [31:0] ia, input bit kill,
                        input bit dr, input bit dwe, input logic [3:0] dbe,
                        input logic [31:0] da, input logic [31:0] dwd);
        bit e_if, e_dp;
        logic [31:0] ga;
        exp_t e;
        @(posedge clk);
        #1;
        if_req = ir; if_addr = ia; if_kill = kill;
        dp_req = dr; dp_we = dwe; dp_be = dbe; dp_addr = da; dp_wdata = dwd;
        #1;
        e_if = ir && (!dr || losses == STARVE);
        e_dp = dr && !e_if;
        ga = e_dp ? da : ia;
        chk("if_gnt", 32'(if_gnt), 32'(e_if));
        chk("dp_gnt", 32'(dp_gnt), 32'(e_dp));
        chk("mem_en", 32'(mem_en), 32'(e_if | e_dp));
        if (e_if || e_dp) begin
            chk("mem_addr", 32'(mem_addr), 32'(ga[31:2]));
            chk("mem_we", 32'(mem_we), 32'(e_dp && dwe));
            chk("mem_be", 32'(mem_be), 32'((e_dp && dwe) ? dbe : 4'hF));
            if (e_dp && dwe) chk("mem_wdata", mem_wdata, dwd);
        end
        if (e_if || (e_dp && !dwe)) begin
            e.at = ncyc + 1;
            e.is_if = e_if;
            e.is_dp = e_dp;
            e.data = ref_mem[ga[9:2]];
            exp_q.push_back(e);
        end
        if (e_dp && dwe)
            for (int b = 0; b < 4; b++)
                if (dbe[b]) ref_mem[ga[9:2]][8*b +: 8] = dwd[8*b +: 8];
        if (e_if || !ir) losses = 0;
        else losses++;
        last_if = e_if;
        last_dp = e_dp;
    endtask

    task automatic idle();
        step(0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    // Response monitor: runs every cycle mid-way between edges, after the
    // driver has applied that cycle's if_kill.
    initial begin
        exp_t e;
        bit   e_if;
        forever begin
            @(posedge clk);
            #3;
            if (mon_en) begin
                while (exp_q.size() > 0 && exp_q[0].at < ncyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL resp_missed: expected response at cycle %0d not observed", e.at);
                end
                if (exp_q.size() > 0 && exp_q[0].at == ncyc) begin
                    e = exp_q.pop_front();
                    e_if = e.is_if && !if_kill;
                    chk("if_rvalid", 32'(if_rvalid), 32'(e_if));
                    chk("dp_rvalid", 32'(dp_rvalid), 32'(e.is_dp));
                    if (e_if) chk("if_rdata", if_rdata, e.data);
                    if (e.is_dp) chk("dp_rdata", dp_rdata, e.data);
                end else begin
                    chk("if_rvalid_idle", 32'(if_rvalid), 32'(0));
                    chk("dp_rvalid_idle", 32'(dp_rvalid), 32'(0));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        bit          pi, pd, pd_we;
        logic [31:0] pi_addr, pd_addr, pd_wdata;
        logic [3:0]  pd_be;
        logic [11:0] pat;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        // Reset state: requests present but nothing may be granted.
        reset = 1'b1;
        if_req = 1'b1; if_addr = 32'h100; if_kill = 1'b0;
        dp_req = 1'b1; dp_we = 1'b0; dp_be = 4'h0; dp_addr = 32'h200; dp_wdata = 32'h0;
        #2;
        chk("rst_if_gnt", 32'(if_gnt), 32'(0));
        chk("rst_dp_gnt", 32'(dp_gnt), 32'(0));
        chk("rst_mem_en", 32'(mem_en), 32'(0));
        chk("rst_if_rvalid", 32'(if_rvalid), 32'(0));
        chk("rst_dp_rvalid", 32'(dp_rvalid), 32'(0));
        @(posedge clk); @(posedge clk);
        #1;
        if_req = 1'b0; dp_req = 1'b0;
        #1;
        reset = 1'b0;
        mon_en = 1;

        // Single fetch of 0x100 (word 0x40 holds 0x13).
        step(1, 32'h100, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        idle();

        // Partial write then read-back of 0x204.
        step(0, 32'h0, 0, 1, 1, 4'h3, 32'h204, 32'hDEADBEEF);
        idle();
        step(0, 32'h0, 0, 1, 0, 4'h0, 32'h204, 32'h0);
        idle();

        // Kill: first fetch response is cancelled, the fetch issued alongside
        // the kill still returns.
        step(1, 32'h100, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        step(1, 32'h104, 1, 0, 0, 4'h0, 32'h0, 32'h0);
        idle();

        // Build up a partial starvation count, then reset with a read in flight.
        step(1, 32'h180, 0, 1, 0, 4'h0, 32'h10, 32'h0);
        step(1, 32'h180, 0, 1, 0, 4'h0, 32'h14, 32'h0);
        step(1, 32'h180, 0, 1, 0, 4'h0, 32'h300, 32'h0);
        @(posedge clk);
        #1;
        if_req = 1'b0; dp_req = 1'b0;
        #3;
        mon_en = 0;
        exp_q.delete();
        reset = 1'b1;
        #1;
        chk("midrst_dp_rvalid", 32'(dp_rvalid), 32'(0));
        chk("midrst_if_rvalid", 32'(if_rvalid), 32'(0));
        if_req = 1'b1; dp_req = 1'b1; dp_we = 1'b0;
        #1;
        chk("midrst_if_gnt", 32'(if_gnt), 32'(0));
        chk("midrst_dp_gnt", 32'(dp_gnt), 32'(0));
        chk("midrst_mem_en", 32'(mem_en), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_hold_dp_rvalid", 32'(dp_rvalid), 32'(0));
        chk("midrst_hold_mem_en", 32'(mem_en), 32'(0));
        if_req = 1'b0; dp_req = 1'b0;
        #1;
        reset = 1'b0;
        losses = 0;
        mon_en = 1;

        // Starvation: continuous conflict, fetch forced every STARVE+1 cycles.
        pat = '0;
        pi_addr = 32'h400;
        for (int i = 0; i < 12; i++) begin
            step(1, pi_addr, 0, 1, 0, 4'h0, $urandom, 32'h0);
            pat[i] = if_gnt;
            if (last_if) pi_addr = pi_addr + 32'd4;
        end
        chk("starve_pattern", 32'(pat), 32'h210);
        idle();

        // Alternating fetch / data read.
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) step(1, $urandom, 0, 0, 0, 4'h0, 32'h0, 32'h0);
            else            step(0, 32'h0, 0, 1, 0, 4'h0, $urandom, 32'h0);
        end
        idle();

        // Randomized traffic; an ungranted request is held until granted.
        pi = 0; pd = 0;
        pd_we = 0; pd_be = 4'h0; pd_addr = 32'h0; pd_wdata = 32'h0;
        for (int i = 0; i < 400; i++) begin
            if (!pi) begin
                pi = ($urandom_range(0, 99) < 60);
                pi_addr = $urandom;
            end
            if (!pd) begin
                pd = ($urandom_range(0, 99) < 70);
                pd_we = $urandom_range(0, 1) == 1;
                pd_be = 4'($urandom);
                pd_addr = $urandom;
                pd_wdata = $urandom;
            end
            step(pi, pi_addr, $urandom_range(0, 4) == 0, pd, pd_we, pd_be, pd_addr, pd_wdata);
            if (last_if) pi = 0;
            if (last_dp) pd = 0;
        end
        idle();
        idle();
        @(posedge clk);
        #4;
        chk("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
